// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bp_pkg
//  Description : Shared definitions for the bimodal branch predictor:
//                2-bit counter encoding, default table size, the PC
//                don't-care value shared with the hazard FSM and the
//                saturating step function.
//  Revision    : 1.0 - initial release
// ============================================================================
package bp_pkg;

    // 2-bit counter encoding; bit 1 is the predicted direction
    localparam logic [1:0] SNT = 2'b00;   // strong not-taken
    localparam logic [1:0] WNT = 2'b01;   // weak not-taken
    localparam logic [1:0] WT  = 2'b10;   // weak taken
    localparam logic [1:0] ST  = 2'b11;   // strong taken

    // log2 of the default number of table entries
    localparam int DEF_INDEX_BITS = 6;

    // PC value driven by the hazard FSM when no branch is in ID
    localparam logic [31:0] PC_DONT_CARE = 32'h0000_0000;

    // One saturating step towards taken (up=1) or not-taken (up=0)
    function automatic logic [1:0] sat_step(input logic [1:0] cnt, input logic up);
        logic [1:0] res;
        res = cnt;
        if (up) begin
            if (cnt != ST) res = cnt + 2'd1;
        end else begin
            if (cnt != SNT) res = cnt - 2'd1;
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter2.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter2
//  Description : One 2-bit saturating counter cell with enable and
//                direction. Holds its value when not enabled.
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter2
    import bp_pkg::*;
#(
    parameter logic [1:0] CNT_INIT = WNT
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       en_i,
    input  logic       up_i,
    output logic [1:0] cnt_o
);

    logic [1:0] cnt_q;
    logic [1:0] cnt_d;

    // Next value: step in the requested direction only when enabled
    always_comb begin
        cnt_d = cnt_q;
        if (en_i) cnt_d = sat_step(cnt_q, up_i);
    end

    // Counter register, returns to the initial value on reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= CNT_INIT;
        else          cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/branch_predictor_bimodal.sv
`default_nettype none
// ============================================================================
//  Module      : branch_predictor_bimodal
//  Description : Bimodal branch predictor. A table of 2-bit saturating
//                counters indexed by halfword-aligned PC bits gives a
//                zero-latency prediction for the branch in ID and trains
//                from the resolved outcome one cycle later. Saturating
//                branch / mispredict counters support performance debug.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor_bimodal
    import bp_pkg::*;
#(
    parameter int         INDEX_BITS = DEF_INDEX_BITS,
    parameter logic [1:0] CNT_INIT   = WNT,
    parameter int         STAT_BITS  = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 lookup_valid,
    input  logic [31:0]          lookup_pc,
    output logic                 predict_taken,
    input  logic                 update_valid,
    input  logic [31:0]          update_pc,
    input  logic                 update_taken,
    input  logic                 update_mispredict,
    output logic [STAT_BITS-1:0] stat_branches,
    output logic [STAT_BITS-1:0] stat_mispredicts
);

    localparam int ENTRIES = 1 << INDEX_BITS;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_UPD  = 1'b1;

    // Bit 0 is dropped: compressed branches sit on 2-byte boundaries.
    // Bits above INDEX_BITS alias on purpose.
    logic [INDEX_BITS-1:0] lookup_idx;
    logic [INDEX_BITS-1:0] update_idx;
    assign lookup_idx = lookup_pc[INDEX_BITS:1];
    assign update_idx = update_pc[INDEX_BITS:1];

    // Prediction is don't-care when no branch is in ID, and the
    // remaining PC bits carry no index information.
    logic unused_ok;
    assign unused_ok = ^{lookup_valid, lookup_pc[31:INDEX_BITS+1], lookup_pc[0],
                         update_pc[31:INDEX_BITS+1], update_pc[0]};

    logic [1:0] cnt_tbl [ENTRIES];

    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_table
            localparam logic [INDEX_BITS-1:0] C_IDX = INDEX_BITS'(gi);
            logic wr_en;
            assign wr_en = update_valid && (update_idx == C_IDX);

            sat_counter2 #(
                .CNT_INIT (CNT_INIT)
            ) u_cnt (
                .clk     (clk),
                .reset_n (reset_n),
                .en_i    (wr_en),
                .up_i    (update_taken),
                .cnt_o   (cnt_tbl[gi])
            );
        end
    endgenerate

    // Read straight from registered state: a same-cycle update to the same
    // entry is not bypassed and shows up the following cycle.
    assign predict_taken = cnt_tbl[lookup_idx][1];

    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------
    logic [STAT_BITS-1:0] stat_br_q, stat_br_d;
    logic [STAT_BITS-1:0] stat_mp_q, stat_mp_d;

    // Saturating increments; a mispredict flag without an update is ignored
    always_comb begin
        stat_br_d = stat_br_q;
        stat_mp_d = stat_mp_q;
        if (update_valid) begin
            if (stat_br_q != '1) stat_br_d = stat_br_q + STAT_BITS'(1);
            if (update_mispredict && (stat_mp_q != '1))
                stat_mp_d = stat_mp_q + STAT_BITS'(1);
        end
    end

    // Statistics registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_br_q <= '0;
            stat_mp_q <= '0;
        end else begin
            stat_br_q <= stat_br_d;
            stat_mp_q <= stat_mp_d;
        end
    end

    assign stat_branches    = stat_br_q;
    assign stat_mispredicts = stat_mp_q;

    // ------------------------------------------------------------------
    // Update-pipeline tracker (observation only; table writes ignore it)
    // ------------------------------------------------------------------
    logic [0:0] state_q, state_d;
    logic       upd_busy;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next state: back-to-back updates keep the tracker in UPD
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = update_valid ? S_UPD : S_IDLE;
            S_UPD:   state_d = update_valid ? S_UPD : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        upd_busy = (state_q == S_UPD);
    end

    a_upd_tracked: assert property (@(posedge clk) disable iff (!reset_n)
        update_valid |=> upd_busy);

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor_bimodal.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_predictor_bimodal
//  Description : Directed bench for the bimodal predictor. Stimulus pushes
//                hand-computed expectations; a monitor pops and compares
//                them whenever a lookup is presented.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predictor_bimodal;

    localparam int STAT_BITS = 4;

    logic                 clk;
    logic                 reset_n;
    logic                 lookup_valid;
    logic [31:0]          lookup_pc;
    logic                 predict_taken;
    logic                 update_valid;
    logic [31:0]          update_pc;
    logic                 update_taken;
    logic                 update_mispredict;
    logic [STAT_BITS-1:0] stat_branches;
    logic [STAT_BITS-1:0] stat_mispredicts;

    branch_predictor_bimodal #(
        .INDEX_BITS (6),
        .CNT_INIT   (2'b01),
        .STAT_BITS  (STAT_BITS)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .lookup_valid      (lookup_valid),
        .lookup_pc         (lookup_pc),
        .predict_taken     (predict_taken),
        .update_valid      (update_valid),
        .update_pc         (update_pc),
        .update_taken      (update_taken),
        .update_mispredict (update_mispredict),
        .stat_branches     (stat_branches),
        .stat_mispredicts  (stat_mispredicts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       p;
        logic [3:0] sb;
        logic [3:0] sm;
        string      tag;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One cycle of stimulus, driven just after the rising edge
    task automatic dr(input logic lv, input logic [31:0] lpc,
                      input logic uv, input logic [31:0] upc,
                      input logic ut, input logic um,
                      input logic ep, input logic [3:0] esb, input logic [3:0] esm,
                      input string tag);
        @(posedge clk);
        #1;
        lookup_valid      = lv;
        lookup_pc         = lpc;
        update_valid      = uv;
        update_pc         = upc;
        update_taken      = ut;
        update_mispredict = um;
        if (lv) sb_q.push_back('{ep, esb, esm, tag});
    endtask

    // Monitor: compare on the falling edge whenever a lookup is presented
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n && lookup_valid) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL scoreboard_empty: lookup seen with no expectation");
                end else begin
                    e = sb_q.pop_front();
                    chk({e.tag, "_pred"}, 16'(predict_taken),    16'(e.p));
                    chk({e.tag, "_sb"},   16'(stat_branches),    16'(e.sb));
                    chk({e.tag, "_sm"},   16'(stat_mispredicts), 16'(e.sm));
                end
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        lookup_valid = 1'b0; lookup_pc = 32'h0;
        update_valid = 1'b0; update_pc = 32'h0;
        update_taken = 1'b0; update_mispredict = 1'b0;
        #12 reset_n = 1'b1;

        // Reset state; a mispredict flag without update_valid must be ignored
        dr(1, 32'h100, 0, 32'h0,   0, 1, 0, 0, 0, "reset");
        // Three taken updates: 01 -> 10 -> 11 -> 11, no bypass on collision
        dr(1, 32'h100, 1, 32'h100, 1, 0, 0, 0, 0, "t1");
        dr(1, 32'h100, 1, 32'h100, 1, 0, 1, 1, 0, "t2");
        dr(1, 32'h100, 1, 32'h100, 1, 0, 1, 2, 0, "t3");
        dr(1, 32'h100, 0, 32'h0,   0, 0, 1, 3, 0, "sat_hi");
        // Not-taken walk down: 11 -> 10 -> 01 (second one mispredicts)
        dr(1, 32'h100, 1, 32'h100, 0, 0, 1, 3, 0, "nt1");
        dr(1, 32'h100, 0, 32'h0,   0, 0, 1, 4, 0, "after_nt1");
        dr(1, 32'h100, 1, 32'h100, 0, 1, 1, 4, 0, "nt2");
        dr(1, 32'h100, 0, 32'h0,   0, 0, 0, 5, 1, "after_nt2");
        for (int k = 0; k < 5; k++)
            dr(1, 32'h100, 1, 32'h100, 0, 0, 0, 4'(5 + k), 1, "nt_sat");
        dr(1, 32'h100, 0, 32'h0,   0, 0, 0, 10, 1, "sat_lo");
        // From 00 one taken gives 01 (still not-taken)
        dr(1, 32'h100, 1, 32'h100, 1, 0, 0, 10, 1, "lo_probe");
        dr(1, 32'h100, 0, 32'h0,   0, 0, 0, 11, 1, "lo_hold");
        // Aliasing: 0x102 and 0x182 share index 1; 0x100 is index 0
        dr(1, 32'h102, 1, 32'h102, 1, 0, 0, 11, 1, "alias_t1");
        dr(1, 32'h182, 1, 32'h102, 1, 0, 1, 12, 1, "alias_t2");
        dr(1, 32'h102, 0, 32'h0,   0, 0, 1, 13, 1, "alias_102");
        dr(1, 32'h182, 0, 32'h0,   0, 0, 1, 13, 1, "alias_182");
        dr(1, 32'h100, 0, 32'h0,   0, 0, 0, 13, 1, "alias_100");
        // Same-cycle collision on index 0 (entry 01)
        dr(1, 32'h200, 1, 32'h200, 1, 0, 0, 13, 1, "collide");
        dr(1, 32'h200, 0, 32'h0,   0, 0, 1, 14, 1, "collide_next");
        // Statistics saturation: 20 mispredicting taken updates to 0x340
        for (int k = 0; k < 20; k++)
            dr(0, 32'h200, 1, 32'h340, 1, 1, 0, 0, 0, "");
        dr(1, 32'h340, 0, 32'h0,   0, 0, 1, 15, 15, "stat_sat");

        // Asynchronous reset mid-stream with an update pending
        @(posedge clk);
        #1;
        lookup_valid = 1'b0; lookup_pc = 32'h340;
        update_valid = 1'b1; update_pc = 32'h340;
        update_taken = 1'b0; update_mispredict = 1'b1;
        #1;
        chk("pre_reset_pred", 16'(predict_taken), 16'h1);
        reset_n = 1'b0;
        #1;
        chk("async_rst_sb",   16'(stat_branches),    16'h0);
        chk("async_rst_sm",   16'(stat_mispredicts), 16'h0);
        chk("async_rst_p340", 16'(predict_taken),    16'h0);
        lookup_pc = 32'h102;
        #1;
        chk("async_rst_p102", 16'(predict_taken),    16'h0);
        @(posedge clk);
        #2;
        update_valid = 1'b0; update_mispredict = 1'b0;
        reset_n = 1'b1;

        // Pending update was lost; entry is back at 01
        dr(1, 32'h340, 0, 32'h0,   0, 0, 0, 0, 0, "post_rst_340");
        dr(1, 32'h102, 0, 32'h0,   0, 0, 0, 0, 0, "post_rst_102");
        dr(1, 32'h340, 1, 32'h340, 1, 0, 0, 0, 0, "post_rst_t");
        dr(1, 32'h340, 0, 32'h0,   0, 0, 1, 1, 0, "post_rst_next");
        dr(0, 32'h0,   0, 32'h0,   0, 0, 0, 0, 0, "");

        // Bounded drain of the scoreboard
        for (int w = 0; w < 4 && sb_q.size() != 0; w++) @(posedge clk);
        chk("scoreboard_drained", 16'(sb_q.size()), 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
